uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates the Receiver, buffers completed bytes in a
// small first-word-fall-through buffer, flags dropped bytes, and marks the
// end of a packet once the line has been idle for TIMEOUT_STICKS ticks.
module uart_rx_ctrl #(
   parameter int SIZE_DATA      = 8,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_STICKS = 160
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_stick,
   input  logic                       i_enable,
   input  logic [SIZE_DATA-1:0]       i_rx_data,
   input  logic                       i_rx_done,
   input  logic                       i_ready,
   input  logic                       i_clr_ovf,
   output logic                       o_rx_en,
   output logic                       o_fifo_full,
   output logic [SIZE_DATA-1:0]       o_data,
   output logic                       o_valid,
   output logic                       o_pkt_end,
   output logic                       o_overflow,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_STICKS > 1) ? $clog2(TIMEOUT_STICKS) : 1;

   typedef enum logic [1:0] {DISABLED, ARMED, ACTIVE} state_t;

   state_t                          state;
   logic [TW-1:0]                   timer;
   logic [DEPTH-1:0][SIZE_DATA-1:0] mem;
   logic [AW-1:0]                   wr_ptr, rd_ptr, rd_ptr_n;
   logic [CW-1:0]                   keep, count_n;
   logic                            push, pop, drop;

   // Buffer handshakes; full is the registered flag, so a pop in the same
   // cycle never makes room for a byte that arrives while full.
   always_comb begin
      push     = i_rx_done & ~o_fifo_full;
      drop     = i_rx_done &  o_fifo_full;
      pop      = o_valid & i_ready;
      keep     = o_count - CW'(pop);
      count_n  = keep + CW'(push);
      rd_ptr_n = rd_ptr + AW'(pop);
   end

   // Byte storage; contents need no reset since count gates visibility.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_rx_data;
   end

   // Pointers, count and registered head/flags; the incoming byte bypasses
   // storage when it becomes the head of an otherwise empty buffer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_count     <= '0;
         o_valid     <= 1'b0;
         o_fifo_full <= 1'b0;
         o_data      <= '0;
      end else begin
         wr_ptr      <= wr_ptr + AW'(push);
         rd_ptr      <= rd_ptr_n;
         o_count     <= count_n;
         o_valid     <= (count_n != '0);
         o_fifo_full <= (count_n == CW'(DEPTH));
         o_data      <= (keep == '0 && push) ? i_rx_data : mem[rd_ptr_n];
      end
   end

   // Sticky overflow; a new drop beats a clear in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)       o_overflow <= 1'b0;
      else if (drop)      o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
   end

   // Enable/packet FSM with idle timer; disable overrides everything.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= DISABLED;
         timer     <= '0;
         o_rx_en   <= 1'b0;
         o_pkt_end <= 1'b0;
      end else begin
         o_pkt_end <= 1'b0;
         if (!i_enable) begin
            state   <= DISABLED;
            o_rx_en <= 1'b0;
         end else begin
            case (state)
               DISABLED: begin
                  state   <= ARMED;
                  o_rx_en <= 1'b1;
               end
               ARMED: begin
                  if (i_rx_done) begin
                     state <= ACTIVE;
                     timer <= '0;
                  end
               end
               ACTIVE: begin
                  if (i_rx_done) begin
                     timer <= '0;
                  end else if (i_stick) begin
                     if (timer == TW'(TIMEOUT_STICKS - 1)) begin
                        state     <= ARMED;
                        timer     <= '0;
                        o_pkt_end <= 1'b1;
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
               end
               default: begin
                  state   <= DISABLED;
                  o_rx_en <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
